// File: rtl/cursor_ctrl.sv
// Byte-stream command interpreter: printable chars, C0 controls and VT52 escapes
// into cursor moves, character writes and scroll requests. Optional macro: CURSOR_AUTOWRAP_EN.
module cursor_ctrl #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7,
  parameter int LAST_ROW = 23,
  parameter int LAST_COL = 79
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          data,
  input  logic                valid,
  output logic                ready,
  input  logic [COL_BITS-1:0] cur_x,
  input  logic [ROW_BITS-1:0] cur_y,
  output logic [COL_BITS-1:0] new_x,
  output logic [ROW_BITS-1:0] new_y,
  output logic                cursor_wen,
  output logic [7:0]          char_out,
  output logic                char_wen,
  output logic                scroll
);

  localparam logic [COL_BITS:0] LAST_COL_E = (COL_BITS+1)'(LAST_COL);
  localparam logic [ROW_BITS:0] LAST_ROW_E = (ROW_BITS+1)'(LAST_ROW);
  localparam logic [COL_BITS:0] X_ONE      = (COL_BITS+1)'(1);
  localparam logic [COL_BITS:0] X_EIGHT    = (COL_BITS+1)'(8);
  localparam logic [ROW_BITS:0] Y_ONE      = (ROW_BITS+1)'(1);
  localparam logic [7:0]        LAST_COL_B = 8'(LAST_COL);
  localparam logic [7:0]        LAST_ROW_B = 8'(LAST_ROW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ESC   = 2'd1,
    ST_Y_ROW = 2'd2,
    ST_Y_COL = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  cwen_q, cwen_d;
  logic                  chwen_q, chwen_d;
  logic                  scroll_q, scroll_d;
  logic [COL_BITS-1:0]   new_x_q, new_x_d;
  logic [ROW_BITS-1:0]   new_y_q, new_y_d;
  logic [7:0]            char_q, char_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic                  row_ok_q, row_ok_d;

  logic [COL_BITS:0]     x_ext_s, x_inc_s, x_tab_s;
  logic [ROW_BITS:0]     y_ext_s, y_inc_s;
  logic [COL_BITS-1:0]   x_incc_s, x_decc_s, x_tabc_s;
  logic [ROW_BITS-1:0]   y_incc_s, y_decc_s, lf_y_s;
  logic                  lf_sc_s;
  logic [8:0]            off_s;
  logic                  row_in_s, col_in_s;
  logic [COL_BITS-1:0]   pr_x_s, ht_x_s;
  logic [ROW_BITS-1:0]   pr_y_s, ht_y_s;
  logic                  pr_sc_s, ht_sc_s;

  // Widened arithmetic so increments clamp instead of wrapping
  always_comb begin
    x_ext_s  = {1'b0, cur_x};
    y_ext_s  = {1'b0, cur_y};
    x_inc_s  = x_ext_s + X_ONE;
    y_inc_s  = y_ext_s + Y_ONE;
    x_tab_s  = {1'b0, cur_x[COL_BITS-1:3], 3'b000} + X_EIGHT;
    x_incc_s = (x_inc_s > LAST_COL_E) ? LAST_COL_E[COL_BITS-1:0] : x_inc_s[COL_BITS-1:0];
    x_tabc_s = (x_tab_s > LAST_COL_E) ? LAST_COL_E[COL_BITS-1:0] : x_tab_s[COL_BITS-1:0];
    y_incc_s = (y_inc_s > LAST_ROW_E) ? LAST_ROW_E[ROW_BITS-1:0] : y_inc_s[ROW_BITS-1:0];
    x_decc_s = (x_ext_s == {(COL_BITS+1){1'b0}}) ? {COL_BITS{1'b0}} : cur_x - X_ONE[COL_BITS-1:0];
    y_decc_s = (y_ext_s == {(ROW_BITS+1){1'b0}}) ? {ROW_BITS{1'b0}} : cur_y - Y_ONE[ROW_BITS-1:0];
    lf_sc_s  = (y_ext_s >= LAST_ROW_E);
    lf_y_s   = lf_sc_s ? cur_y : y_inc_s[ROW_BITS-1:0];
    off_s    = {1'b0, data} - 9'h020;
    row_in_s = !off_s[8] && (off_s[7:0] <= LAST_ROW_B);
    col_in_s = !off_s[8] && (off_s[7:0] <= LAST_COL_B);
  end

`ifdef CURSOR_AUTOWRAP_EN
  logic at_last_col_s;

  // Printable/HT at the last column wrap to the next line, scrolling at the bottom
  always_comb begin
    at_last_col_s = (x_ext_s >= LAST_COL_E);
    if (at_last_col_s) begin
      pr_x_s  = {COL_BITS{1'b0}};
      pr_y_s  = lf_y_s;
      pr_sc_s = lf_sc_s;
    end else begin
      pr_x_s  = x_incc_s;
      pr_y_s  = cur_y;
      pr_sc_s = 1'b0;
    end
    if (at_last_col_s) begin
      ht_x_s  = {COL_BITS{1'b0}};
      ht_y_s  = lf_y_s;
      ht_sc_s = lf_sc_s;
    end else begin
      ht_x_s  = x_tabc_s;
      ht_y_s  = cur_y;
      ht_sc_s = 1'b0;
    end
  end
`else
  always_comb begin
    pr_x_s  = x_incc_s;
    pr_y_s  = cur_y;
    pr_sc_s = 1'b0;
    ht_x_s  = x_tabc_s;
    ht_y_s  = cur_y;
    ht_sc_s = 1'b0;
  end
`endif

  // Next-state decode for one accepted byte
  always_comb begin
    state_d  = state_q;
    cwen_d   = 1'b0;
    chwen_d  = 1'b0;
    scroll_d = 1'b0;
    new_x_d  = new_x_q;
    new_y_d  = new_y_q;
    char_d   = char_q;
    row_d    = row_q;
    row_ok_d = row_ok_q;
    if (valid && ready_q) begin
      case (state_q)
        ST_IDLE: begin
          if (data == 8'h1B) begin
            state_d = ST_ESC;
          end else if (data == 8'h0D) begin
            cwen_d = 1'b1; new_x_d = {COL_BITS{1'b0}}; new_y_d = cur_y;
          end else if (data == 8'h08) begin
            cwen_d = 1'b1; new_x_d = x_decc_s; new_y_d = cur_y;
          end else if (data == 8'h09) begin
            cwen_d = 1'b1; new_x_d = ht_x_s; new_y_d = ht_y_s; scroll_d = ht_sc_s;
          end else if (data == 8'h0A) begin
            cwen_d = 1'b1; new_x_d = cur_x; new_y_d = lf_y_s; scroll_d = lf_sc_s;
          end else if ((data >= 8'h20) && (data <= 8'h7E)) begin
            chwen_d = 1'b1; char_d = data;
            cwen_d  = 1'b1; new_x_d = pr_x_s; new_y_d = pr_y_s; scroll_d = pr_sc_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ESC: begin
          state_d = ST_IDLE;
          case (data)
            8'h41:   begin cwen_d = 1'b1; new_x_d = cur_x;    new_y_d = y_decc_s; end
            8'h42:   begin cwen_d = 1'b1; new_x_d = cur_x;    new_y_d = y_incc_s; end
            8'h43:   begin cwen_d = 1'b1; new_x_d = x_incc_s; new_y_d = cur_y;    end
            8'h44:   begin cwen_d = 1'b1; new_x_d = x_decc_s; new_y_d = cur_y;    end
            8'h48:   begin cwen_d = 1'b1; new_x_d = {COL_BITS{1'b0}}; new_y_d = {ROW_BITS{1'b0}}; end
            8'h59:   state_d = ST_Y_ROW;
            8'h1B:   state_d = ST_ESC;
            default: state_d = ST_IDLE;
          endcase
        end
        ST_Y_ROW: begin
          row_d    = off_s[ROW_BITS-1:0];
          row_ok_d = row_in_s;
          state_d  = ST_Y_COL;
        end
        ST_Y_COL: begin
          cwen_d  = 1'b1;
          new_x_d = col_in_s ? off_s[COL_BITS-1:0] : cur_x;
          new_y_d = row_ok_q ? row_q : cur_y;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    // Stall one cycle after any write so cur_x/cur_y are current for the next byte
    ready_d = ~(cwen_d | chwen_d);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      cwen_q   <= 1'b0;
      chwen_q  <= 1'b0;
      scroll_q <= 1'b0;
      new_x_q  <= {COL_BITS{1'b0}};
      new_y_q  <= {ROW_BITS{1'b0}};
      char_q   <= 8'h00;
      row_q    <= {ROW_BITS{1'b0}};
      row_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cwen_q   <= cwen_d;
      chwen_q  <= chwen_d;
      scroll_q <= scroll_d;
      new_x_q  <= new_x_d;
      new_y_q  <= new_y_d;
      char_q   <= char_d;
      row_q    <= row_d;
      row_ok_q <= row_ok_d;
    end
  end

  assign ready      = ready_q;
  assign cursor_wen = cwen_q;
  assign char_wen   = chwen_q;
  assign scroll     = scroll_q;
  assign new_x      = new_x_q;
  assign new_y      = new_y_q;
  assign char_out   = char_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl: directed byte stream, expected strobes queued
// at stimulus time and checked by an independent output monitor.
module tb_cursor_ctrl;

  typedef struct packed {
    logic       cw;
    logic       chw;
    logic       sc;
    logic [6:0] x;
    logic [4:0] y;
    logic [7:0] ch;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic [6:0] new_x;
  logic [4:0] new_y;
  logic       cursor_wen;
  logic [7:0] char_out;
  logic       char_wen;
  logic       scroll;

  exp_t q[$];
  int   n_checks;
  int   n_fail;

  cursor_ctrl dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .cur_x(cur_x), .cur_y(cur_y), .new_x(new_x), .new_y(new_y),
    .cursor_wen(cursor_wen), .char_out(char_out), .char_wen(char_wen), .scroll(scroll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cursor position register sitting downstream of the DUT
  always @(posedge clk) begin
    if (reset) begin
      cur_x <= 7'd0;
      cur_y <= 5'd0;
    end else if (cursor_wen) begin
      cur_x <= new_x;
      cur_y <= new_y;
    end
  end

  // Output monitor: every strobe cycle must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (cursor_wen || char_wen || scroll)) begin
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_stall: ready=%b required 0 in strobe cycle", ready);
      end
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: cwen=%b chwen=%b scroll=%b x=%0d y=%0d", cursor_wen, char_wen, scroll, new_x, new_y);
      end else begin
        e = q.pop_front();
        if (cursor_wen !== e.cw || char_wen !== e.chw || scroll !== e.sc ||
            (e.cw && (new_x !== e.x || new_y !== e.y)) || (e.chw && char_out !== e.ch)) begin
          n_fail++;
          $display("FAIL strobe: got cwen=%b chwen=%b scroll=%b x=%0d y=%0d ch=%h, required cwen=%b chwen=%b scroll=%b x=%0d y=%0d ch=%h",
                   cursor_wen, char_wen, scroll, new_x, new_y, char_out, e.cw, e.chw, e.sc, e.x, e.y, e.ch);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_mv(input int x, input int y, input logic sc);
    exp_t e;
    e = '{cw: 1'b1, chw: 1'b0, sc: sc, x: 7'(x), y: 5'(y), ch: 8'h00};
    q.push_back(e);
  endtask

  task automatic exp_ch(input logic [7:0] c, input int x, input int y, input logic sc);
    exp_t e;
    e = '{cw: 1'b1, chw: 1'b1, sc: sc, x: 7'(x), y: 5'(y), ch: c};
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int cnt;
    cnt = 0;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    while (!ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready=%b required 1 for byte %h", ready, b);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic goto_xy(input int x, input int y);
    send(8'h1B); send(8'h59); send(8'(y + 32));
    exp_mv(x, y, 1'b0);
    send(8'(x + 32));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || cursor_wen !== 1'b0 || char_wen !== 1'b0 || scroll !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b cwen=%b chwen=%b scroll=%b required all 0", ready, cursor_wen, char_wen, scroll);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || new_x !== 7'd0 || new_y !== 5'd0 || char_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b x=%0d y=%0d ch=%h required 1,0,0,00", ready, new_x, new_y, char_out);
    end

    // Printable at origin
    exp_ch(8'h41, 1, 0, 1'b0); send(8'h41);
    // ESC Y absolute positioning, including out-of-range row/col bytes
    goto_xy(16, 5);
    send(8'h1B); send(8'h59); send(8'h7F); exp_mv(16, 5, 1'b0); send(8'h30);
    send(8'h1B); send(8'h59); send(8'h1F); exp_mv(16, 5, 1'b0); send(8'h70);
    // Clamps at top-left
    send(8'h1B); exp_mv(0, 0, 1'b0); send(8'h48);
    send(8'h1B); exp_mv(0, 0, 1'b0); send(8'h41);
    send(8'h1B); exp_mv(0, 0, 1'b0); send(8'h44);
    // Clamps at bottom-right, LF scroll, printable at last column
    goto_xy(79, 23);
    send(8'h1B); exp_mv(79, 23, 1'b0); send(8'h43);
    send(8'h1B); exp_mv(79, 23, 1'b0); send(8'h42);
    exp_mv(79, 23, 1'b1); send(8'h0A);
`ifdef CURSOR_AUTOWRAP_EN
    exp_ch(8'h42, 0, 23, 1'b1); send(8'h42);
`else
    exp_ch(8'h42, 79, 23, 1'b0); send(8'h42);
`endif
    // HT capping, LF mid-screen, CR and BS
    goto_xy(77, 10);
    exp_mv(79, 10, 1'b0); send(8'h09);
    exp_mv(79, 11, 1'b0); send(8'h0A);
    exp_mv(0, 11, 1'b0);  send(8'h0D);
    exp_mv(0, 11, 1'b0);  send(8'h08);
    goto_xy(3, 10);
    exp_mv(8, 10, 1'b0);  send(8'h09);
    exp_mv(7, 10, 1'b0);  send(8'h08);
    // Ignored bytes produce no strobes; ESC ESC C stays in escape then moves
    send(8'h01); send(8'h7F); send(8'h80); send(8'hFF);
    send(8'h1B); send(8'h5A);
    send(8'h1B); send(8'h1B); exp_mv(8, 10, 1'b0); send(8'h43);
    // Reset mid ESC Y: following byte is a plain printable
    send(8'h1B); send(8'h59); send(8'h25);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_ch(8'h30, 1, 0, 1'b0); send(8'h30);
    // Printable range edges
    exp_ch(8'h20, 2, 0, 1'b0); send(8'h20);
    exp_ch(8'h7E, 3, 0, 1'b0); send(8'h7E);

    repeat (6) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected strobes never seen, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
